// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to one shared WIDTH-bit register.
// Optional burst lock (requester keeps the grant across writes) when ARB_LOCK_EN is defined.
module shared_reg_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]         lock,
`endif
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        q,
  output logic                    q_valid,
  output logic                    busy
);

  localparam int unsigned IW = $clog2(NREQ);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [IW-1:0]    id_q, id_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qv_q, qv_d;

  logic             found;
  logic [IW-1:0]    win;
  int unsigned      idx;
  logic             lock_hold;

  // Scan from the requester after the last completed grant, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = (int'(ptr_q) + off) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

`ifdef ARB_LOCK_EN
  assign lock_hold = lock[id_q] & req[id_q];
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    id_d    = id_q;
    ptr_d   = ptr_q;
    q_d     = q_q;
    qv_d    = qv_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StGrant;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          id_d       = win;
        end
      end
      StGrant: begin
        if (req[id_q]) begin
          state_d = StWrite;
        end else begin
          // Requester withdrew: drop the grant without writing or moving the pointer.
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
      StWrite: begin
        q_d         = wdata[id_q*WIDTH +: WIDTH];
        qv_d        = 1'b1;
        ack_d[id_q] = 1'b1;
        ptr_d       = id_q;
        if (lock_hold) begin
          state_d = StGrant;
        end else begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ack_q   <= '0;
      id_q    <= '0;
      ptr_q   <= IW'(NREQ - 1);
      q_q     <= '0;
      qv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign ack     = ack_q;
  assign q       = q_q;
  assign q_valid = qv_q;
  assign busy    = (state_q != StIdle);

endmodule
